robs_mult_scheduler: RTL and testbench

- Shares one Robertson's signed multiplier datapath (robsmult) among NREQ requesters.
- Arbitrates requests round-robin and latches the winner's operands.
- Launches the multiplier by pulsing its reset, waits for done, then returns the product to the winner with a valid/ready handshake.
- Sits between client FSMs and a single robsmult instance.

---
 rtl/robs_mult_scheduler.sv | 145 ++++++++++++++
 tb/tb_robs_mult_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/robs_mult_scheduler.sv
// Round-robin scheduler sharing one Robertson's signed multiplier among NREQ requesters.
// One job in flight: accept in IDLE, pulse mul_reset, wait for an armed done or timeout, hold the result until taken.
module robs_mult_scheduler #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         resp_valid,
  input  logic [NREQ-1:0]         resp_ready,
  output logic [2*WIDTH-1:0]      resp_product,
  output logic                    resp_err,
  output logic                    mul_reset,
  output logic [WIDTH-1:0]        mul_multiplier,
  output logic [WIDTH-1:0]        mul_multiplicand,
  input  logic [2*WIDTH-1:0]      mul_product,
  input  logic                    mul_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               err_q, err_d;
  logic               armed_q, armed_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               win_vld;
  logic [IW-1:0]      win_idx;
  int unsigned        cand;
  logic               done_hit;
  logic               to_hit;

  // First requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % NREQ;
      if (!win_vld && req_valid[cand]) begin
        win_vld = 1'b1;
        win_idx = IW'(cand);
      end
    end
  end

  // Armed gate keeps a done left over from the previous job from completing this one.
  assign done_hit = armed_q & mul_done;
  assign to_hit   = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    prod_d     = prod_q;
    err_d      = err_q;
    armed_d    = armed_q;
    cnt_d      = cnt_q;
    req_ready  = '0;
    resp_valid = '0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          req_ready[win_idx] = ~reset;
          owner_d            = win_idx;
          op_a_d             = req_a[win_idx*WIDTH +: WIDTH];
          op_b_d             = req_b[win_idx*WIDTH +: WIDTH];
          state_d            = LAUNCH;
        end
      end
      LAUNCH: begin
        armed_d = 1'b0;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (!mul_done) armed_d = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (done_hit) begin
          prod_d  = mul_product;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (to_hit) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid[owner_q] = ~reset;
        if (resp_ready[owner_q]) begin
          rr_ptr_d = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      prod_q   <= '0;
      err_q    <= 1'b0;
      armed_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      prod_q   <= prod_d;
      err_q    <= err_d;
      armed_q  <= armed_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mul_reset        = reset | (state_q == LAUNCH);
  assign mul_multiplier   = op_a_q;
  assign mul_multiplicand = op_b_q;
  assign resp_product     = prod_q;
  assign resp_err         = err_q;

endmodule

// File: tb/tb_robs_mult_scheduler.sv
// Bench for robs_mult_scheduler: directed jobs, a behavioural multiplier with stuck-done modes,
// and a per-cycle scoreboard built on job-level timing arithmetic.
`timescale 1ns/1ps
module tb_robs_mult_scheduler;
  localparam int WIDTH   = 8;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int LAT     = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ-1:0]       resp_valid;
  logic [NREQ-1:0]       resp_ready = '1;
  logic [2*WIDTH-1:0]    resp_product;
  logic                  resp_err;
  logic                  mul_reset;
  logic [WIDTH-1:0]      mul_multiplier, mul_multiplicand;
  logic [2*WIDTH-1:0]    mul_product;
  logic                  mul_done;

  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];
  int remaining [NREQ];
  int mode = 0;
  int nchk = 0, nerr = 0, cyc = 0, rdy_cnt = 0;
  int          log_own [$];
  logic [15:0] log_prod [$];
  logic        log_err [$];
  int          log_lat [$];
  logic [NREQ-1:0] acc_seen;

  robs_mult_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_product(resp_product), .resp_err(resp_err),
    .mul_reset(mul_reset), .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
    .mul_product(mul_product), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_a[g*WIDTH +: WIDTH] = op_a[g];
    assign req_b[g*WIDTH +: WIDTH] = op_b[g];
  end

  // Behavioural multiplier: result LAT cycles after restart; modes 1/2 force done high/low.
  int          mcnt = 0;
  logic        mdone_r = 1'b0;
  logic [15:0] mprod_r = '0;
  logic signed [15:0] mx, my;
  assign mx = {{8{mul_multiplier[7]}}, mul_multiplier};
  assign my = {{8{mul_multiplicand[7]}}, mul_multiplicand};
  always @(posedge clk) begin
    if (mul_reset) begin
      mcnt    <= LAT;
      mdone_r <= 1'b0;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        mdone_r <= 1'b1;
        mprod_r <= mx * my;
      end
    end
  end
  assign mul_done    = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : mdone_r;
  assign mul_product = (mode == 0) ? mprod_r : 16'hDEAD;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: a job accepted at cycle A launches at A+1 and answers at A+3+LAT, or A+2+TIMEOUT on timeout.
  bit          busy = 0;
  int          rr = 0, own = 0, acc_cyc = 0, resp_cyc = 0, win = 0;
  logic [7:0]  ea, eb;
  logic signed [15:0] sa, sb;
  logic [15:0] eprod;
  logic        eerr;
  initial forever begin
    @(negedge clk);
    cyc++;
    if (reset) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_mul_reset", mul_reset, 1);
      busy = 0;
      rr   = 0;
    end else if (!busy) begin
      win = -1;
      for (int k = 0; k < NREQ; k++)
        if (win < 0 && req_valid[(rr + k) % NREQ]) win = (rr + k) % NREQ;
      chk("idle_req_ready", req_ready, (win >= 0) ? (1 << win) : 0);
      chk("idle_resp_valid", resp_valid, 0);
      chk("idle_mul_reset", mul_reset, 0);
      if (req_ready != 0) rdy_cnt++;
      if (win >= 0) begin
        busy    = 1;
        own     = win;
        acc_cyc = cyc;
        ea      = op_a[win];
        eb      = op_b[win];
        if (mode == 0) begin
          sa       = {{8{ea[7]}}, ea};
          sb       = {{8{eb[7]}}, eb};
          eprod    = sa * sb;
          eerr     = 1'b0;
          resp_cyc = acc_cyc + 3 + LAT;
        end else begin
          eprod    = 16'h0000;
          eerr     = 1'b1;
          resp_cyc = acc_cyc + 2 + TIMEOUT;
        end
      end
    end else begin
      chk("busy_req_ready", req_ready, 0);
      chk("mul_reset_pulse", mul_reset, (cyc == acc_cyc + 1) ? 1 : 0);
      if (cyc < resp_cyc) begin
        chk("mul_multiplier", mul_multiplier, ea);
        chk("mul_multiplicand", mul_multiplicand, eb);
        chk("early_resp_valid", resp_valid, 0);
      end else begin
        chk("resp_valid", resp_valid, 1 << own);
        chk("resp_product", resp_product, eprod);
        chk("resp_err", resp_err, eerr);
        if (resp_ready[own]) begin
          log_own.push_back(own);
          log_prod.push_back(resp_product);
          log_err.push_back(resp_err);
          log_lat.push_back(resp_cyc - acc_cyc);
          busy = 0;
          rr   = (own + 1) % NREQ;
        end
      end
    end
  end

  // Client side: each requester holds req_valid until it has been accepted 'remaining' times.
  initial forever begin
    @(negedge clk);
    acc_seen = req_valid & req_ready;
    @(posedge clk);
    #2;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_seen[i] && remaining[i] > 0) remaining[i]--;
      req_valid[i] = (remaining[i] > 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b, input int n);
    op_a[i] = a;
    op_b[i] = b;
    remaining[i] = n;
  endtask

  task automatic wait_log(input int n, input int budget);
    int k = 0;
    while (log_own.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (log_own.size() < n) begin
      nchk++;
      nerr++;
      $display("FAIL wait_log: got %0d responses, required %0d", log_own.size(), n);
    end
  endtask

  task automatic chk_log(input string nm, input int idx, input int o, input logic [15:0] p, input logic e);
    if (idx >= log_own.size()) begin
      nchk++;
      nerr++;
      $display("FAIL %s: response %0d missing", nm, idx);
    end else begin
      chk({nm, "_owner"}, log_own[idx], o);
      chk({nm, "_product"}, log_prod[idx], p);
      chk({nm, "_err"}, log_err[idx], e);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r0, k;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
      remaining[i] = 0;
    end
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_req_ready", req_ready, 0);
    chk("post_reset_resp_valid", resp_valid, 0);
    chk("post_reset_product", resp_product, 0);
    chk("post_reset_err", resp_err, 0);
    tick(1);

    // Single request and signed operands
    r0 = rdy_cnt;
    issue(0, 8'd3, 8'd5, 1);
    wait_log(1, 100);
    chk_log("single", 0, 0, 16'h000F, 1'b0);
    chk("single_ready_pulses", rdy_cnt - r0, 1);
    if (log_lat.size() > 0) chk("single_latency", log_lat[0], 7);
    tick(1);
    issue(2, 8'hFD, 8'h05, 1);
    wait_log(2, 100);
    chk_log("neg_times_pos", 1, 2, 16'hFFF1, 1'b0);
    tick(1);
    issue(2, 8'h80, 8'h80, 1);
    wait_log(3, 100);
    chk_log("min_times_min", 2, 2, 16'h4000, 1'b0);

    // Fairness from a fresh pointer
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    issue(0, 8'd1, 8'd2, 1);
    issue(1, 8'hFF, 8'hFF, 1);
    issue(2, 8'd7, 8'hF9, 1);
    issue(3, 8'd12, 8'd11, 1);
    wait_log(7, 200);
    chk_log("rr0", 3, 0, 16'h0002, 1'b0);
    chk_log("rr1", 4, 1, 16'h0001, 1'b0);
    chk_log("rr2", 5, 2, 16'hFFCF, 1'b0);
    chk_log("rr3", 6, 3, 16'h0084, 1'b0);
    tick(1);
    issue(0, 8'd2, 8'd2, 2);
    issue(2, 8'd3, 8'd3, 2);
    wait_log(11, 200);
    chk_log("alt0", 7, 0, 16'h0004, 1'b0);
    chk_log("alt1", 8, 2, 16'h0009, 1'b0);
    chk_log("alt2", 9, 0, 16'h0004, 1'b0);
    chk_log("alt3", 10, 2, 16'h0009, 1'b0);

    // Backpressure on requester 1 while requester 3 offers a stray ready
    tick(1);
    resp_ready = 4'b1000;
    issue(1, 8'h7F, 8'h81, 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!resp_valid[1] && k < 100);
    chk("bp_valid_seen", resp_valid, 4'b0010);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", resp_valid, 4'b0010);
      chk("bp_hold_product", resp_product, 16'hC0FF);
      chk("bp_hold_ready", req_ready, 0);
    end
    @(posedge clk);
    #1;
    resp_ready = 4'b1111;
    wait_log(12, 50);
    chk_log("bp_release", 11, 1, 16'hC0FF, 1'b0);

    // Stale done stuck high, then done stuck low
    tick(1);
    mode = 1;
    issue(0, 8'd3, 8'd5, 1);
    wait_log(13, 200);
    chk_log("stuck_high", 12, 0, 16'h0000, 1'b1);
    if (log_lat.size() > 12) chk("timeout_latency", log_lat[12], 66);
    tick(1);
    mode = 2;
    issue(2, 8'd4, 8'd4, 1);
    wait_log(14, 200);
    chk_log("stuck_low", 13, 2, 16'h0000, 1'b1);
    tick(1);
    mode = 0;

    // Reset while waiting on the multiplier
    issue(3, 8'h0A, 8'hF6, 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(mul_reset && !reset) && k < 50);
    chk("abort_launch_seen", mul_reset, 1);
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(10);
    chk("abort_no_response", log_own.size(), 14);
    issue(3, 8'h0A, 8'hF6, 1);
    issue(1, 8'd2, 8'd3, 1);
    wait_log(16, 200);
    chk_log("after_abort_first", 14, 1, 16'h0006, 1'b0);
    chk_log("after_abort_second", 15, 3, 16'hFF9C, 1'b0);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
